// File: rtl/micro_sequencer.sv
// Next-address controller for the 11-bit microaddress counter: decodes the
// sequencing field into HOLD/INC/LOAD and keeps a return-address stack for call/return.
package microaddr;
  typedef enum logic [1:0] {HOLD = 2'd0, INC = 2'd1, LOAD = 2'd2} cmd;
endpackage

module micro_sequencer #(
  parameter int STACK_DEPTH = 4,
  parameter int COND_W      = 8,
  localparam int DW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         seq_op,
  input  logic [10:0]        target,
  input  logic [2:0]         cond_sel,
  input  logic               cond_pol,
  input  logic [COND_W-1:0]  cond,
  input  logic [10:0]        dispatch_addr,
  input  logic               stall,
  input  logic [10:0]        addr,
  output microaddr::cmd      cmd,
  output logic [10:0]        load_addr,
  output logic [DW-1:0]      depth,
  output logic               stack_err
);
  localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_BRANCH = 3'd2, OP_CALL = 3'd3,
                         OP_RET  = 3'd4, OP_DISP = 3'd5, OP_WAIT   = 3'd6;

  logic [10:0] stack [STACK_DEPTH];
  logic [10:0] top;
  logic [7:0]  cond_pad;
  logic        cond_true, push, pop, err_set, full, empty;

  // Zero-extension makes any cond_sel beyond COND_W read as a 0 flag.
  assign cond_pad  = 8'(cond);
  assign cond_true = cond_pad[cond_sel] ^ cond_pol;
  assign full      = (depth == DW'(STACK_DEPTH));
  assign empty     = (depth == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (DW'(i + 1) == depth) top = stack[i];
  end

  always_comb begin
    cmd       = microaddr::HOLD;
    load_addr = '0;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    if (reset) begin
      cmd = microaddr::LOAD;
    end else if (!stall) begin
      case (seq_op)
        OP_JUMP: begin
          cmd       = microaddr::LOAD;
          load_addr = target;
        end
        OP_BRANCH: begin
          if (cond_true) begin
            cmd       = microaddr::LOAD;
            load_addr = target;
          end else begin
            cmd = microaddr::INC;
          end
        end
        OP_CALL: begin
          // The jump is taken even when the push has to be dropped.
          cmd       = microaddr::LOAD;
          load_addr = target;
          if (full) err_set = 1'b1;
          else      push    = 1'b1;
        end
        OP_RET: begin
          if (!empty) begin
            cmd       = microaddr::LOAD;
            load_addr = top;
            pop       = 1'b1;
          end else begin
            cmd     = microaddr::INC;
            err_set = 1'b1;
          end
        end
        OP_DISP: begin
          cmd       = microaddr::LOAD;
          load_addr = dispatch_addr;
        end
        OP_WAIT: cmd = cond_true ? microaddr::INC : microaddr::HOLD;
        default: cmd = microaddr::INC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth     <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      stack_err <= stack_err | err_set;
      if (push) begin
        for (int i = 0; i < STACK_DEPTH; i++)
          if (DW'(i) == depth) stack[i] <= addr + 11'd1;
        depth <= depth + 1'b1;
      end else if (pop) begin
        depth <= depth - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; a behavioural microaddress counter closes the loop.
module tb_micro_sequencer;
  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    seq_op;
  logic [10:0]   target;
  logic [2:0]    cond_sel;
  logic          cond_pol;
  logic [7:0]    cond;
  logic [10:0]   dispatch_addr;
  logic          stall;
  logic [10:0]   addr;
  microaddr::cmd cmd;
  logic [10:0]   load_addr;
  logic [2:0]    depth;
  logic          stack_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [15:0] C_HOLD = 16'd0, C_INC = 16'd1, C_LOAD = 16'd2;

  micro_sequencer #(.STACK_DEPTH(4), .COND_W(8)) dut (
    .clk(clk), .reset(reset), .seq_op(seq_op), .target(target), .cond_sel(cond_sel),
    .cond_pol(cond_pol), .cond(cond), .dispatch_addr(dispatch_addr), .stall(stall),
    .addr(addr), .cmd(cmd), .load_addr(load_addr), .depth(depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd == microaddr::LOAD)     addr <= load_addr;
    else if (cmd == microaddr::INC) addr <= addr + 11'd1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] o, input logic [10:0] t);
    seq_op = o;
    target = t;
    #1;
  endtask

  initial begin
    reset = 1'b1; seq_op = 3'd0; target = '0; cond_sel = '0; cond_pol = 1'b0;
    cond = '0; dispatch_addr = '0; stall = 1'b0;
    #1;
    chk("rst_cmd", 16'(cmd), C_LOAD);
    chk("rst_load", 16'(load_addr), 16'h000);
    step();
    reset = 1'b0;
    chk("rst_addr", 16'(addr), 16'h000);
    chk("rst_depth", 16'(depth), 16'd0);
    chk("rst_err", 16'(stack_err), 16'd0);

    for (int i = 1; i <= 3; i++) begin
      op(3'd0, 11'h000);
      chk("next_cmd", 16'(cmd), C_INC);
      step();
      chk("next_addr", 16'(addr), 16'(i));
    end
    chk("next_depth", 16'(depth), 16'd0);
    op(3'd7, 11'h555);
    chk("rsvd_cmd", 16'(cmd), C_INC);
    step();
    chk("rsvd_addr", 16'(addr), 16'h004);

    op(3'd5, 11'h000); dispatch_addr = 11'h0AB; #1;
    chk("disp_load", 16'(load_addr), 16'h0AB);
    step();
    chk("disp_addr", 16'(addr), 16'h0AB);

    // Branch taken, then not taken with inverted polarity.
    op(3'd1, 11'h010); step();
    cond = 8'h04; cond_sel = 3'd2; cond_pol = 1'b0;
    op(3'd2, 11'h200);
    chk("br_t_cmd", 16'(cmd), C_LOAD);
    chk("br_t_load", 16'(load_addr), 16'h200);
    step();
    chk("br_t_addr", 16'(addr), 16'h200);
    op(3'd1, 11'h010); step();
    cond_pol = 1'b1;
    op(3'd2, 11'h200);
    chk("br_n_cmd", 16'(cmd), C_INC);
    chk("br_n_load", 16'(load_addr), 16'h000);
    step();
    chk("br_n_addr", 16'(addr), 16'h011);
    cond_pol = 1'b0;

    // Nested call/return.
    op(3'd1, 11'h020); step();
    op(3'd3, 11'h100); step();
    chk("c1_addr", 16'(addr), 16'h100); chk("c1_depth", 16'(depth), 16'd1);
    op(3'd3, 11'h300); step();
    chk("c2_addr", 16'(addr), 16'h300); chk("c2_depth", 16'(depth), 16'd2);
    op(3'd4, 11'h000);
    chk("r1_load", 16'(load_addr), 16'h101);
    step();
    chk("r1_addr", 16'(addr), 16'h101); chk("r1_depth", 16'(depth), 16'd1);
    op(3'd4, 11'h000); step();
    chk("r2_addr", 16'(addr), 16'h021); chk("r2_depth", 16'(depth), 16'd0);

    // Five calls into a 4-deep stack: the fifth jumps but drops its push.
    for (int i = 0; i < 5; i++) begin
      op(3'd3, 11'h400 + 11'(i * 16)); step();
    end
    chk("ovf_addr", 16'(addr), 16'h440);
    chk("ovf_depth", 16'(depth), 16'd4);
    chk("ovf_err", 16'(stack_err), 16'd1);
    op(3'd4, 11'h000); step(); chk("u1_addr", 16'(addr), 16'h421);
    op(3'd4, 11'h000); step(); chk("u2_addr", 16'(addr), 16'h411);
    op(3'd4, 11'h000); step(); chk("u3_addr", 16'(addr), 16'h401);
    op(3'd4, 11'h000); step(); chk("u4_addr", 16'(addr), 16'h022);
    chk("u4_depth", 16'(depth), 16'd0);
    op(3'd4, 11'h000);
    chk("und_cmd", 16'(cmd), C_INC);
    step();
    chk("und_addr", 16'(addr), 16'h023);
    chk("und_depth", 16'(depth), 16'd0);
    op(3'd0, 11'h000); step();
    chk("err_sticky", 16'(stack_err), 16'd1);

    // Wait on flag 0 low, then high.
    cond = 8'h00; cond_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      op(3'd6, 11'h000);
      chk("wait_cmd", 16'(cmd), C_HOLD);
      step();
      chk("wait_addr", 16'(addr), 16'h024);
    end
    cond = 8'h01; #1;
    chk("wait_go", 16'(cmd), C_INC);
    step();
    chk("wait_addr2", 16'(addr), 16'h025);

    // Stalled call has no effect until released.
    stall = 1'b1;
    op(3'd3, 11'h500);
    chk("stl_cmd", 16'(cmd), C_HOLD);
    step();
    chk("stl_depth", 16'(depth), 16'd0);
    chk("stl_addr", 16'(addr), 16'h025);
    stall = 1'b0; #1;
    chk("unstl_cmd", 16'(cmd), C_LOAD);
    step();
    chk("unstl_addr", 16'(addr), 16'h500);
    chk("unstl_depth", 16'(depth), 16'd1);

    // Return address wraps from the top of the address space.
    op(3'd1, 11'h7FF); step();
    op(3'd3, 11'h600); step();
    chk("wrap_depth", 16'(depth), 16'd2);
    op(3'd4, 11'h000);
    chk("wrap_cmd", 16'(cmd), C_LOAD);
    chk("wrap_load", 16'(load_addr), 16'h000);
    step();
    chk("wrap_addr", 16'(addr), 16'h000);

    // Reset in the middle of a subroutine at depth 3.
    op(3'd3, 11'h050); step();
    op(3'd3, 11'h060); step();
    chk("pre_rst_depth", 16'(depth), 16'd3);
    chk("pre_rst_err", 16'(stack_err), 16'd1);
    reset = 1'b1; #1;
    chk("mid_rst_cmd", 16'(cmd), C_LOAD);
    chk("mid_rst_load", 16'(load_addr), 16'h000);
    step();
    reset = 1'b0;
    chk("post_rst_depth", 16'(depth), 16'd0);
    chk("post_rst_addr", 16'(addr), 16'h000);
    chk("post_rst_err", 16'(stack_err), 16'd0);
    op(3'd4, 11'h000);
    chk("post_rst_ret", 16'(cmd), C_INC);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
